// File: rtl/dff_bank_pkg.sv
// rtl/dff_bank_pkg.sv - shared types and defaults for the flip-flop bank arbiter
package dff_bank_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        LOAD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin search starting at ptr
module rr_pick
    import dff_bank_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] cand;

    // First set request at or after ptr; the index wraps naturally because NREQ is a power of two.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr + k[IW-1:0];
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - round-robin owner of a shared WIDTH-bit register bank
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH-1:0]        q
);

    localparam int IW = $clog2(NREQ);

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_n;
    logic [IW-1:0]   owner_n;
    logic [IW-1:0]   owner_inc;
    logic [NREQ-1:0] gnt_n;
    logic            busy_n;
    logic            done_n;
    logic            load_en;
    logic            owner_req;
    logic [WIDTH-1:0] owner_word;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Only the current owner's request line matters once a grant is out.
    assign owner_req = req[owner];
    assign owner_inc = owner + IW'(1);

    // Select the owner's write word for the bank input.
    always_comb begin
        owner_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == i[IW-1:0]) begin
                owner_word = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state and next registered outputs; aborts and releases both move ptr past the owner.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        gnt_n   = gnt;
        busy_n  = busy;
        done_n  = 1'b0;
        load_en = 1'b0;
        case (state)
            IDLE: begin
                gnt_n  = '0;
                busy_n = 1'b0;
                if (pick_valid) begin
                    state_n         = GRANT;
                    owner_n         = pick_idx;
                    gnt_n[pick_idx] = 1'b1;
                    busy_n          = 1'b1;
                end
            end
            GRANT: begin
                if (owner_req) begin
                    state_n = LOAD;
                end else begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                    ptr_n   = owner_inc;
                end
            end
            LOAD: begin
                if (owner_req) begin
                    state_n = RELEASE;
                    load_en = 1'b1;
                    gnt_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                    ptr_n   = owner_inc;
                end
            end
            RELEASE: begin
                state_n = IDLE;
                gnt_n   = '0;
                busy_n  = 1'b0;
                ptr_n   = owner_inc;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // Control registers; reset discards any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            gnt   <= gnt_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // The shared bank itself; it only loads on a successful LOAD cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load_en) begin
            q <= owner_word;
        end
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb/tb_dff_bank_arbiter.sv - directed scoreboard bench for dff_bank_arbiter
module tb_dff_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic        done;
    logic [7:0]  q;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int prev_gnt_cyc;
    int gap;
    int rr_order [4] = '{0, 1, 3, 0};

    typedef struct packed {
        logic [1:0] owner;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   done_cycles [$];

    dff_bank_arbiter #(
        .NREQ  (4),
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .done  (done),
        .q     (q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every done must match the oldest expected write.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cycles.push_back(cyc);
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected_done: observed owner=%0d q=%0h, required no done", owner, q);
            end
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checks++;
                assert ({owner, q} === {mon_e.owner, mon_e.data}) else begin
                    errors++;
                    $error("FAIL sb_done_word: observed owner=%0d q=%0h, required owner=%0d q=%0h",
                           owner, q, mon_e.owner, mon_e.data);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with every requester asking
        rst_n = 1'b0;
        req   = 4'b1111;
        wdata = 32'h44332211;
        step();
        step();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_q", 32'(q), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        rst_n = 1'b1;
        exp_q.push_back('{owner: 2'd0, data: 8'h11});
        step();
        check("rst_first_gnt", 32'(gnt), 32'h1);
        check("rst_first_busy", 32'(busy), 32'h1);
        req = 4'b0001;
        step();
        step();
        req = 4'b0000;
        step();

        // Single write from requester 2
        do_reset();
        wdata = 32'h44A52211;
        req   = 4'b0100;
        exp_q.push_back('{owner: 2'd2, data: 8'hA5});
        step();
        check("sw_gnt", 32'(gnt), 32'h4);
        check("sw_busy", 32'(busy), 32'h1);
        check("sw_owner", 32'(owner), 32'h2);
        step();
        check("sw_load_gnt", 32'(gnt), 32'h4);
        check("sw_load_done", 32'(done), 32'h0);
        check("sw_load_q", 32'(q), 32'h0);
        step();
        check("sw_q", 32'(q), 32'hA5);
        check("sw_done", 32'(done), 32'h1);
        check("sw_owner_done", 32'(owner), 32'h2);
        check("sw_rel_gnt", 32'(gnt), 32'h0);
        req = 4'b0000;
        step();
        check("sw_done_clear", 32'(done), 32'h0);
        check("sw_idle_busy", 32'(busy), 32'h0);

        // Round-robin with requesters 0, 1 and 3 held
        do_reset();
        wdata = 32'h44332211;
        req   = 4'b1011;
        exp_q.push_back('{owner: 2'd0, data: 8'h11});
        exp_q.push_back('{owner: 2'd1, data: 8'h22});
        exp_q.push_back('{owner: 2'd3, data: 8'h44});
        exp_q.push_back('{owner: 2'd0, data: 8'h11});
        done_cycles.delete();
        prev_gnt_cyc = 0;
        for (int n = 0; n < 4; n++) begin
            step();
            check($sformatf("rr_gnt%0d", n), 32'(gnt), 32'(1) << rr_order[n]);
            if (n > 0) check($sformatf("rr_gap%0d", n), 32'(cyc - prev_gnt_cyc), 32'd4);
            prev_gnt_cyc = cyc;
            step();
            step();
            step();
        end
        req = 4'b0000;
        step();
        check("rr_done_count", 32'(done_cycles.size()), 32'd4);

        // Abort in GRANT, then ptr has moved past requester 1
        do_reset();
        wdata = 32'h44337711;
        req   = 4'b0010;
        step();
        check("ab_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        step();
        check("ab_gnt_clr", 32'(gnt), 32'h0);
        check("ab_busy", 32'(busy), 32'h0);
        check("ab_done", 32'(done), 32'h0);
        check("ab_q", 32'(q), 32'h0);
        req = 4'b0011;
        exp_q.push_back('{owner: 2'd0, data: 8'h11});
        step();
        check("ab_next_gnt", 32'(gnt), 32'h1);
        step();
        step();
        req = 4'b0000;
        step();

        // Abort in LOAD keeps q and still advances ptr past requester 3
        req = 4'b1000;
        step();
        check("la_gnt", 32'(gnt), 32'h8);
        step();
        req = 4'b0000;
        step();
        check("la_q", 32'(q), 32'h11);
        check("la_done", 32'(done), 32'h0);
        check("la_busy", 32'(busy), 32'h0);
        check("la_gnt_clr", 32'(gnt), 32'h0);
        req = 4'b1001;
        exp_q.push_back('{owner: 2'd0, data: 8'h11});
        step();
        check("la_next_gnt", 32'(gnt), 32'h1);
        step();
        step();
        req = 4'b0000;
        step();

        // Reset arriving during LOAD
        wdata = 32'h443C2211;
        req   = 4'b0100;
        step();
        check("rl_gnt", 32'(gnt), 32'h4);
        step();
        rst_n = 1'b0;
        step();
        check("rl_q", 32'(q), 32'h0);
        check("rl_gnt_clr", 32'(gnt), 32'h0);
        check("rl_done", 32'(done), 32'h0);
        check("rl_busy", 32'(busy), 32'h0);
        check("rl_owner", 32'(owner), 32'h0);
        rst_n = 1'b1;
        req   = 4'b1001;
        step();
        check("rl_ptr_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        step();
        step();

        // Late requester 3 rising during requester 0's LOAD
        do_reset();
        wdata = 32'hD43322C1;
        req   = 4'b0001;
        exp_q.push_back('{owner: 2'd0, data: 8'hC1});
        exp_q.push_back('{owner: 2'd3, data: 8'hD4});
        done_cycles.delete();
        step();
        step();
        req = 4'b1001;
        step();
        check("lt_done0", 32'(done), 32'h1);
        check("lt_rel_gnt", 32'(gnt), 32'h0);
        req = 4'b1000;
        step();
        check("lt_idle_gnt", 32'(gnt), 32'h0);
        step();
        check("lt_gnt3", 32'(gnt), 32'h8);
        step();
        step();
        check("lt_done3", 32'(done), 32'h1);
        check("lt_q3", 32'(q), 32'hD4);
        req = 4'b0000;
        step();
        step();
        check("lt_done_count", 32'(done_cycles.size()), 32'd2);
        gap = (done_cycles.size() >= 2) ? (done_cycles[1] - done_cycles[0]) : -1;
        check("lt_done_gap", 32'(gap), 32'd4);

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin controller that shares one WIDTH-bit storage register, the flip-flop bank, among NREQ requesters. Each requester raises `req`, receives a one-hot grant, and holds its write word until the arbiter loads it into the bank and pulses `done`. It sits between the requester logic and the storage bank. It is the only block allowed to drive the bank's load enable.

## Interface
- `NREQ`, 4, number of requesters (power of two, 2..8)
- `WIDTH`, 8, data width of the shared bank
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; synchronous and active-low
- `req`  in  NREQ  request, one bit per requester; level, held until `done` or abort
- `wdata`  in  NREQ*WIDTH  write words; requester i drives bits [i*WIDTH +: WIDTH]
- `gnt`  out  NREQ  one-hot grant; all zero when nobody owns the bank
- `owner`  out  $clog2(NREQ)  index of the current or last granted requester
- `busy`  out  1  high in GRANT, LOAD and RELEASE
- `done`  out  1  one-cycle pulse; the bank has just captured the owner's word
- `q`  out  WIDTH  bank contents

## Operation
- FSM states: IDLE, GRANT, LOAD, RELEASE.
- **IDLE**
  - If any `req` bit is high, pick the first set bit at or after `ptr`, searching upward and wrapping modulo NREQ.
  - Register the pick in `owner`, set `gnt` one-hot and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**: if `req[owner]` is high, go to LOAD; if it is low, abort.
- **LOAD**: if `req[owner]` is high, capture `q <= wdata[owner]` and go to RELEASE; if it is low, abort with no capture.
- **RELEASE**: `gnt` goes to 0 and `done` is 1. Set `ptr <= owner+1`, wrapping at NREQ, and go to IDLE unconditionally.
- **Abort**
  - Go to IDLE and clear `gnt`; `q` is unchanged and `done` stays 0.
  - Still advance `ptr <= owner+1`, so a flaky requester cannot starve the others.
- **Request sampling**
  - `req` is sampled only in IDLE, GRANT and LOAD.
  - Requests raised or dropped by non-owners in any state other than IDLE are ignored until the next IDLE.
- **Arithmetic**: `ptr` and `owner` are $clog2(NREQ) bits wide and wrap naturally; no saturation.
- **Reset** (rst_n low at a clock edge, any state, including mid-transaction):
  - state IDLE
  - `ptr` = 0, `owner` = 0
  - `gnt` = 0, `busy` = 0, `done` = 0
  - `q` = 0
  - An interrupted transaction is discarded with no capture and no `done`.

## Timing
- All outputs are registered. Nothing is combinational from `req` or `wdata` to any output.
- Latency for an uncontended request raised before edge E0:
  - after E0: `gnt` and `busy` are high (GRANT)
  - after E1: LOAD
  - after E2: `q` is updated, `done` = 1 (RELEASE)
  - after E3: back in IDLE; `gnt` was already 0 during RELEASE
- Requester hold rules:
  - `wdata[owner]` must be stable during the LOAD cycle.
  - `req[owner]` must stay high through LOAD.
  - The requester may drop `req` in the RELEASE cycle, i.e. the cycle `done` is high.
- Throughput is one transaction per 4 cycles; IDLE is always visited between grants.
- If a requester still holds `req` after `done`, it is treated as a new request at the next IDLE and is subject to round-robin order.

## Structure
- Shared package `dff_bank_pkg`:
  - `state_t` enum: IDLE=2'd0, GRANT=2'd1, LOAD=2'd2, RELEASE=2'd3
  - default constants NREQ_DEF=4 and WIDTH_DEF=8
- Sub-module `rr_pick`: pure round-robin search (inputs `req` and `ptr`; outputs `valid` and `idx`). It is instantiated once and its result is registered in IDLE.
- The FSM, `ptr`, `owner` and the bank register all live in the top module.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles while req=4'b1111 → `gnt`=0, `q`=0, `done`=0, `busy`=0. Release reset → first grant is `gnt`=4'b0001.
- **Single write:** req[2]=1 with wdata slice 2 = 8'hA5, held → `gnt`=4'b0100 after 1 edge. After 3 edges `q`=8'hA5 and `done` pulses for exactly 1 cycle with `owner`=2.
- **Round-robin:** req=4'b1011 held continuously → grants in order 0, 1, 3, 0. Each `done` shows the matching slice value; a grant starts every 4 cycles.
- **Abort:** req[1] raised, then dropped in GRANT → return to IDLE, no `done`, `q` unchanged. With req=4'b0011 afterwards, the next grant goes to requester 0 because `ptr` wrapped past 1.
- **Reset mid-LOAD:** rst_n=0 during LOAD while the owner's slice is 8'h3C → `q`=0, `gnt`=0, no `done`, `ptr`=0.
- **Late requester:** req[3] rises during requester 0's LOAD → ignored until IDLE, then granted; its `done` arrives exactly 4 cycles after requester 0's `done`.
